// File: rtl/ppg_led_sequencer.sv
// ppg_led_sequencer
// Analog front-end sequencer for the pulse-oximeter loop. Each frame is made of
// three phases: IR, DARK (ambient) and RED. For every phase the block drives the
// LEDs, the DC compensation DAC and the PGA gain. It discards the first
// SETTLE_CYCLES ADC samples, averages the next 2^AVG_LOG2 samples, and reports
// ambient-subtracted IR and RED averages with valid pulses and saturation flags.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_enable       run frames while high; sampled in IDLE and at the end of RED
//   i_dc_ir        DC compensation code used in the IR and DARK phases
//   i_dc_red       DC compensation code used in the RED phase
//   i_pga_ir       PGA gain used in the IR and DARK phases
//   i_pga_red      PGA gain used in the RED phase
//   i_adc          unsigned ADC sample, one per cycle
//   o_led_ir       IR LED enable
//   o_led_red      RED LED enable
//   o_dc_comp      DAC code sent to the front end
//   o_pga_gain     PGA gain sent to the front end
//   o_ir_sample    IR average minus dark average, clamped at 0
//   o_red_sample   RED average minus dark average, clamped at 0
//   o_ir_valid     one-cycle pulse when o_ir_sample/o_ir_sat update
//   o_red_valid    one-cycle pulse when o_red_sample/o_red_sat update
//   o_ir_sat       IR phase saw an acquired sample at 0 or 255
//   o_red_sat      RED phase saw an acquired sample at 0 or 255
//   o_busy         state machine is not IDLE
module ppg_led_sequencer #(
   parameter int SETTLE_CYCLES = 8,
   parameter int AVG_LOG2      = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic [6:0] i_dc_ir,
   input  logic [6:0] i_dc_red,
   input  logic [3:0] i_pga_ir,
   input  logic [3:0] i_pga_red,
   input  logic [7:0] i_adc,
   output logic       o_led_ir,
   output logic       o_led_red,
   output logic [6:0] o_dc_comp,
   output logic [3:0] o_pga_gain,
   output logic [7:0] o_ir_sample,
   output logic [7:0] o_red_sample,
   output logic       o_ir_valid,
   output logic       o_red_valid,
   output logic       o_ir_sat,
   output logic       o_red_sat,
   output logic       o_busy
);

   localparam int         ACC_W      = 8 + AVG_LOG2;
   localparam int         PHASE_LEN  = SETTLE_CYCLES + (1 << AVG_LOG2);
   localparam logic [8:0] CNT_LAST   = 9'(PHASE_LEN - 1);
   localparam logic [8:0] CNT_SETTLE = 9'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_IR   = 2'd1,
      S_DARK = 2'd2,
      S_RED  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [8:0]         r_cnt;
   logic [ACC_W-1:0]   r_acc;
   logic               r_sat_ph;
   logic               r_ir_sat_hold;
   logic [7:0]         r_ir_avg;
   logic [7:0]         r_dark_avg;

   logic               r_led_ir;
   logic               r_led_red;
   logic [6:0]         r_dc_comp;
   logic [3:0]         r_pga_gain;
   logic [7:0]         r_ir_sample;
   logic [7:0]         r_red_sample;
   logic               r_ir_valid;
   logic               r_red_valid;
   logic               r_ir_sat;
   logic               r_red_sat;
   logic               r_busy;

   logic               w_phase_end;
   logic               w_acquire;
   logic [ACC_W-1:0]   w_acc_sum;
   logic [7:0]         w_avg;
   logic               w_adc_sat;
   logic               w_sat_ph;

   // Difference of two averages, clamped at zero when ambient exceeds signal.
   function automatic logic [7:0] sub_clamp(input logic [7:0] a, input logic [7:0] b);
      if (a > b) begin
         return a - b;
      end else begin
         return 8'd0;
      end
   endfunction

   assign w_phase_end = (r_state != S_IDLE) && (r_cnt == CNT_LAST);
   assign w_acquire   = (r_state != S_IDLE) && (r_cnt >= CNT_SETTLE);
   assign w_acc_sum   = r_acc + ACC_W'(i_adc);
   // The average includes the sample arriving on the last phase cycle.
   assign w_avg       = 8'(w_acc_sum >> AVG_LOG2);
   assign w_adc_sat   = (i_adc == 8'd0) || (i_adc == 8'd255);
   assign w_sat_ph    = r_sat_ph | (w_acquire & w_adc_sat);

   // Next-state logic: Enable only matters in IDLE and at the end of RED.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_enable) w_next_state = S_IR;
            else          w_next_state = S_IDLE;
         end
         S_IR: begin
            if (w_phase_end) w_next_state = S_DARK;
            else             w_next_state = S_IR;
         end
         S_DARK: begin
            if (w_phase_end) w_next_state = S_RED;
            else             w_next_state = S_DARK;
         end
         S_RED: begin
            if (w_phase_end && i_enable)  w_next_state = S_IR;
            else if (w_phase_end)         w_next_state = S_IDLE;
            else                          w_next_state = S_RED;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register, phase counter, accumulator and per-phase sticky saturation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 9'd0;
         r_acc    <= {ACC_W{1'b0}};
         r_sat_ph <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_phase_end || (r_state == S_IDLE)) begin
            r_cnt    <= 9'd0;
            r_acc    <= {ACC_W{1'b0}};
            r_sat_ph <= 1'b0;
         end else begin
            r_cnt    <= r_cnt + 9'd1;
            r_sat_ph <= w_sat_ph;
            if (w_acquire) r_acc <= w_acc_sum;
            else           r_acc <= r_acc;
         end
      end
   end

   // Front-end drive and result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_led_ir      <= 1'b0;
         r_led_red     <= 1'b0;
         r_dc_comp     <= 7'd64;
         r_pga_gain    <= 4'd0;
         r_ir_sample   <= 8'd0;
         r_red_sample  <= 8'd0;
         r_ir_valid    <= 1'b0;
         r_red_valid   <= 1'b0;
         r_ir_sat      <= 1'b0;
         r_red_sat     <= 1'b0;
         r_busy        <= 1'b0;
         r_ir_avg      <= 8'd0;
         r_dark_avg    <= 8'd0;
         r_ir_sat_hold <= 1'b0;
      end else begin
         r_ir_valid  <= 1'b0;
         r_red_valid <= 1'b0;
         r_busy      <= (w_next_state != S_IDLE);
         r_led_ir    <= (w_next_state == S_IR);
         r_led_red   <= (w_next_state == S_RED);

         // Settings are captured only on phase entry. DARK keeps the values
         // captured at IR entry so ambient is measured with IR settings.
         if (w_next_state != r_state) begin
            case (w_next_state)
               S_IR: begin
                  r_dc_comp  <= i_dc_ir;
                  r_pga_gain <= i_pga_ir;
               end
               S_DARK: begin
                  r_dc_comp  <= r_dc_comp;
                  r_pga_gain <= r_pga_gain;
               end
               S_RED: begin
                  r_dc_comp  <= i_dc_red;
                  r_pga_gain <= i_pga_red;
               end
               default: begin
                  r_dc_comp  <= 7'd64;
                  r_pga_gain <= 4'd0;
               end
            endcase
         end

         // IR results are published once the same frame's dark average exists.
         if (w_phase_end) begin
            case (r_state)
               S_IR: begin
                  r_ir_avg      <= w_avg;
                  r_ir_sat_hold <= w_sat_ph;
               end
               S_DARK: begin
                  r_dark_avg  <= w_avg;
                  r_ir_sample <= sub_clamp(r_ir_avg, w_avg);
                  r_ir_sat    <= r_ir_sat_hold;
                  r_ir_valid  <= 1'b1;
               end
               S_RED: begin
                  r_red_sample <= sub_clamp(w_avg, r_dark_avg);
                  r_red_sat    <= w_sat_ph;
                  r_red_valid  <= 1'b1;
               end
               default: begin
                  r_ir_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_led_ir     = r_led_ir;
   assign o_led_red    = r_led_red;
   assign o_dc_comp    = r_dc_comp;
   assign o_pga_gain   = r_pga_gain;
   assign o_ir_sample  = r_ir_sample;
   assign o_red_sample = r_red_sample;
   assign o_ir_valid   = r_ir_valid;
   assign o_red_valid  = r_red_valid;
   assign o_ir_sat     = r_ir_sat;
   assign o_red_sat    = r_red_sat;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_ppg_led_sequencer.sv
// tb_ppg_led_sequencer
// Directed frames with hand-computed results. Each frame pushes its expected
// IR and RED results (with the cycle they must appear in) into a scoreboard
// queue; a monitor on the falling edge pops and compares on every valid pulse.
// Phase-level drive outputs are checked inline by the stimulus process.
module tb_ppg_led_sequencer;

   localparam int P = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_enable;
   logic [6:0] i_dc_ir;
   logic [6:0] i_dc_red;
   logic [3:0] i_pga_ir;
   logic [3:0] i_pga_red;
   logic [7:0] i_adc;
   logic       o_led_ir;
   logic       o_led_red;
   logic [6:0] o_dc_comp;
   logic [3:0] o_pga_gain;
   logic [7:0] o_ir_sample;
   logic [7:0] o_red_sample;
   logic       o_ir_valid;
   logic       o_red_valid;
   logic       o_ir_sat;
   logic       o_red_sat;
   logic       o_busy;

   ppg_led_sequencer #(.SETTLE_CYCLES(8), .AVG_LOG2(2)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_enable    (i_enable),
      .i_dc_ir     (i_dc_ir),
      .i_dc_red    (i_dc_red),
      .i_pga_ir    (i_pga_ir),
      .i_pga_red   (i_pga_red),
      .i_adc       (i_adc),
      .o_led_ir    (o_led_ir),
      .o_led_red   (o_led_red),
      .o_dc_comp   (o_dc_comp),
      .o_pga_gain  (o_pga_gain),
      .o_ir_sample (o_ir_sample),
      .o_red_sample(o_red_sample),
      .o_ir_valid  (o_ir_valid),
      .o_red_valid (o_red_valid),
      .o_ir_sat    (o_ir_sat),
      .o_red_sat   (o_red_sat),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      logic       is_red;
      logic [7:0] sample;
      logic       sat;
      int         cyc;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   exp_t       push_e;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] fr[3*P];
   int         base;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (o_ir_valid || o_red_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("valid_kind_red", int'(o_red_valid), int'(mon_e.is_red));
            chk("valid_cycle", edge_cnt, mon_e.cyc);
            if (mon_e.is_red) begin
               chk("red_sample", o_red_sample, mon_e.sample);
               chk("red_sat", o_red_sat, mon_e.sat);
            end else begin
               chk("ir_sample", o_ir_sample, mon_e.sample);
               chk("ir_sat", o_ir_sat, mon_e.sat);
            end
         end
      end
   end

   // One phase worth of ADC data: settle value then four acquired samples.
   task automatic fill(input int ph, input logic [7:0] sv,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] a2, input logic [7:0] a3);
      for (int i = 0; i < 8; i++) fr[ph*P+i] = sv;
      fr[ph*P+8]  = a0;
      fr[ph*P+9]  = a1;
      fr[ph*P+10] = a2;
      fr[ph*P+11] = a3;
   endtask

   // Plays cycles 1..3P of a frame whose edge 0 has already been issued.
   task automatic run_frame(input logic [7:0] ir_exp, input logic ir_sat,
                            input logic [7:0] red_exp, input logic red_sat,
                            input logic [6:0] exp_dc_ir, input int chg_dc_at,
                            input int drop_en_at);
      int ph;
      for (int k = 1; k <= 3*P; k++) begin
         @(negedge clk);
         if (k == 1) begin
            base = edge_cnt;
            push_e.is_red = 1'b0; push_e.sample = ir_exp;  push_e.sat = ir_sat;  push_e.cyc = base + 2*P;
            sb_q.push_back(push_e);
            push_e.is_red = 1'b1; push_e.sample = red_exp; push_e.sat = red_sat; push_e.cyc = base + 3*P;
            sb_q.push_back(push_e);
         end
         ph = (k - 1) / P;
         if (k == 1 || k == P || k == P+1 || k == 2*P || k == 2*P+1 || k == 3*P) begin
            chk("led_ir", o_led_ir, (ph == 0) ? 1 : 0);
            chk("led_red", o_led_red, (ph == 2) ? 1 : 0);
            chk("busy", o_busy, 1);
            chk("dc_comp", o_dc_comp, (ph == 2) ? 33 : int'(exp_dc_ir));
            chk("pga_gain", o_pga_gain, (ph == 2) ? 7 : 3);
         end
         i_adc = fr[k-1];
         if (k == chg_dc_at) i_dc_ir = 7'd90;
         if (k == drop_en_at) i_enable = 1'b0;
      end
   endtask

   task automatic check_idle(input string tag, input logic [7:0] ir_s, input logic [7:0] red_s);
      chk({tag, "_led_ir"}, o_led_ir, 0);
      chk({tag, "_led_red"}, o_led_red, 0);
      chk({tag, "_dc_comp"}, o_dc_comp, 64);
      chk({tag, "_pga_gain"}, o_pga_gain, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_ir_valid"}, o_ir_valid, 0);
      chk({tag, "_ir_sample"}, o_ir_sample, ir_s);
      chk({tag, "_red_sample"}, o_red_sample, red_s);
   endtask

   initial begin
      rst = 1'b1; i_enable = 1'b0; i_adc = 8'd0;
      i_dc_ir = 7'd20; i_dc_red = 7'd33; i_pga_ir = 4'd3; i_pga_red = 4'd7;
      repeat (3) @(negedge clk);
      check_idle("reset", 8'd0, 8'd0);
      chk("reset_red_valid", o_red_valid, 0);
      chk("reset_ir_sat", o_ir_sat, 0);
      chk("reset_red_sat", o_red_sat, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_hold_busy", o_busy, 0);

      // Frame 1: basic subtraction; DC_IR changes mid-frame without effect.
      i_enable = 1'b1;
      fill(0, 8'd150, 8'd150, 8'd150, 8'd150, 8'd150);
      fill(1, 8'd30, 8'd30, 8'd30, 8'd30, 8'd30);
      fill(2, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
      run_frame(8'd120, 1'b0, 8'd70, 1'b0, 7'd20, 5, 0);

      // Frame 2: dark above IR clamps to 0; new DC_IR now in effect.
      fill(0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
      fill(1, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
      fill(2, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250);
      run_frame(8'd0, 1'b0, 8'd50, 1'b0, 7'd90, 0, 0);

      // Frame 3: truncating average, settle samples ignored, RED saturation.
      fill(0, 8'd255, 8'd10, 8'd11, 8'd11, 8'd11);
      fill(1, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
      fill(2, 8'd100, 8'd100, 8'd255, 8'd100, 8'd100);
      run_frame(8'd5, 1'b0, 8'd133, 1'b1, 7'd90, 0, 0);

      // Frame 4: clean data clears RED_Sat; Enable drops mid-frame.
      fill(0, 8'd0, 8'd50, 8'd50, 8'd50, 8'd50);
      fill(1, 8'd0, 8'd10, 8'd10, 8'd10, 8'd10);
      fill(2, 8'd0, 8'd60, 8'd60, 8'd60, 8'd60);
      run_frame(8'd40, 1'b0, 8'd50, 1'b0, 7'd90, 0, 10);
      @(negedge clk);
      check_idle("after_drop", 8'd40, 8'd50);

      // Partial frame aborted by reset in cycle 18.
      @(negedge clk);
      i_enable = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         i_adc = 8'd150;
         if (k == 18) rst = 1'b1;
      end
      @(negedge clk);
      check_idle("mid_reset", 8'd0, 8'd0);
      chk("mid_reset_ir_sat", o_ir_sat, 0);
      chk("mid_reset_red_sat", o_red_sat, 0);
      rst = 1'b0;
      i_enable = 1'b0;
      repeat (3) @(negedge clk);

      // Frame 5: full timing after reset.
      i_enable = 1'b1;
      fill(0, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
      fill(1, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
      fill(2, 8'd180, 8'd180, 8'd180, 8'd180, 8'd180);
      run_frame(8'd100, 1'b0, 8'd80, 1'b0, 7'd90, 0, 10);
      @(negedge clk);
      check_idle("final_idle", 8'd100, 8'd80);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
